// File: rtl/nap_timer_controller_if.sv
// rtl/nap_timer_controller_if.sv - handshake bundle between the nap sequencer and the keypad time-setting block
//
// Signals
//   setting_en     controller -> setting block : enable keypad entry
//   set_load       setting block -> controller : set_* digits valid this cycle
//   set_complete   setting block -> controller : '#' accepted, entry finished
//   set_hour10 .. set_second1  setting block -> controller : 4-bit BCD digits (unclamped)
// Modports
//   master : the nap sequencer side
//   slave  : the keypad time-setting block side

interface nap_timer_controller_if;
    logic       setting_en;
    logic       set_load;
    logic       set_complete;
    logic [3:0] set_hour10;
    logic [3:0] set_hour1;
    logic [3:0] set_minute10;
    logic [3:0] set_minute1;
    logic [3:0] set_second10;
    logic [3:0] set_second1;

    modport master (
        output setting_en,
        input  set_load,
        input  set_complete,
        input  set_hour10,
        input  set_hour1,
        input  set_minute10,
        input  set_minute1,
        input  set_second10,
        input  set_second1
    );

    modport slave (
        input  setting_en,
        output set_load,
        output set_complete,
        output set_hour10,
        output set_hour1,
        output set_minute10,
        output set_minute1,
        output set_second10,
        output set_second1
    );
endinterface

// File: rtl/nap_timer_controller.sv
// rtl/nap_timer_controller.sv - nap countdown sequencer: hh:mm:ss BCD register, keypad setting, 1 Hz countdown, wake alarm
//
// Parameters
//   ALARM_SECS  ticks the alarm stays up before returning to IDLE (1..255)
//   SNOOZE_MIN  minutes loaded on snooze (single BCD digit, 1..9)
// Ports
//   clock, reset        system clock, synchronous active-low reset
//   tick                1 Hz strobe, one clock wide
//   mode_key            enter setting / snooze (one-cycle pulse)
//   start_key           start/pause toggle, stop alarm (one-cycle pulse)
//   cancel_key          abort and clear time (one-cycle pulse)
//   set_bus             handshake with keypad setting block (master side)
//   hour10 .. second1   registered BCD time digits
//   state               registered state encoding
//   running, alarm      registered status flags

module nap_timer_controller #(
    parameter int ALARM_SECS = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            tick,
    input  logic                            mode_key,
    input  logic                            start_key,
    input  logic                            cancel_key,
    nap_timer_controller_if.master          set_bus,
    output logic [3:0]                      hour10,
    output logic [3:0]                      hour1,
    output logic [3:0]                      minute10,
    output logic [3:0]                      minute1,
    output logic [3:0]                      second10,
    output logic [3:0]                      second1,
    output logic [2:0]                      state,
    output logic                            running,
    output logic                            alarm
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTING = 3'd1,
        ST_ARMED   = 3'd2,
        ST_RUNNING = 3'd3,
        ST_PAUSED  = 3'd4,
        ST_ALARM   = 3'd5,
        ST_RSVD6   = 3'd6,
        ST_RSVD7   = 3'd7
    } state_e;

    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);
    localparam logic [3:0] SNOOZE_DIG = 4'(SNOOZE_MIN);

    // Time register packed as {hour10, hour1, minute10, minute1, second10, second1}.
    state_e      state_q, state_d;
    logic [23:0] time_q, time_d;
    logic [7:0]  alarm_cnt_q, alarm_cnt_d;
    logic        running_q, running_d;
    logic        alarm_q, alarm_d;
    logic        setting_en_q, setting_en_d;

    // One-second BCD decrement; each digit borrows from the next when it is 0.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8] = 4'd9;
                    if (t[15:12] != 4'd0) begin
                        r[15:12] = t[15:12] - 4'd1;
                    end else begin
                        r[15:12] = 4'd5;
                        if (t[19:16] != 4'd0) begin
                            r[19:16] = t[19:16] - 4'd1;
                        end else begin
                            r[19:16] = 4'd9;
                            r[23:20] = t[23:20] - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    logic [23:0] load_time;
    logic [23:0] dec_time;

    always_comb begin
        load_time = {clamp(set_bus.set_hour10,   4'd9),
                     clamp(set_bus.set_hour1,    4'd9),
                     clamp(set_bus.set_minute10, 4'd5),
                     clamp(set_bus.set_minute1,  4'd9),
                     clamp(set_bus.set_second10, 4'd5),
                     clamp(set_bus.set_second1,  4'd9)};
        dec_time  = bcd_dec(time_q);
    end

    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        alarm_cnt_d = alarm_cnt_q;

        // cancel outranks every other key; in IDLE it simply swallows the cycle.
        if (cancel_key) begin
            state_d     = ST_IDLE;
            time_d      = 24'd0;
            alarm_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_key) begin
                        if (time_q != 24'd0) state_d = ST_RUNNING;
                    end else if (mode_key) begin
                        state_d = ST_SETTING;
                    end
                end
                ST_SETTING: begin
                    // A load in the same cycle as complete is judged on the loaded value.
                    if (set_bus.set_load) time_d = load_time;
                    if (set_bus.set_complete) begin
                        state_d = (time_d != 24'd0) ? ST_ARMED : ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (start_key)     state_d = ST_RUNNING;
                    else if (mode_key) state_d = ST_SETTING;
                end
                ST_RUNNING: begin
                    if (tick) begin
                        time_d = dec_time;
                        if (dec_time == 24'd0) begin
                            state_d     = ST_ALARM;
                            alarm_cnt_d = 8'd0;
                        end else if (start_key) begin
                            state_d = ST_PAUSED;
                        end
                    end else if (start_key) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start_key)     state_d = ST_RUNNING;
                    else if (mode_key) state_d = ST_SETTING;
                end
                ST_ALARM: begin
                    if (start_key) begin
                        state_d     = ST_IDLE;
                        alarm_cnt_d = 8'd0;
                    end else if (mode_key) begin
                        time_d      = {8'h00, 4'd0, SNOOZE_DIG, 8'h00};
                        alarm_cnt_d = 8'd0;
                        state_d     = ST_RUNNING;
                    end else if (tick) begin
                        if (alarm_cnt_q == ALARM_LAST) begin
                            state_d     = ST_IDLE;
                            alarm_cnt_d = 8'd0;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Status flags are decoded from the next state so they line up with state_q.
        running_d    = (state_d == ST_RUNNING);
        alarm_d      = (state_d == ST_ALARM);
        setting_en_d = (state_d == ST_SETTING);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            time_q       <= 24'd0;
            alarm_cnt_q  <= 8'd0;
            running_q    <= 1'b0;
            alarm_q      <= 1'b0;
            setting_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            alarm_cnt_q  <= alarm_cnt_d;
            running_q    <= running_d;
            alarm_q      <= alarm_d;
            setting_en_q <= setting_en_d;
        end
    end

    assign hour10             = time_q[23:20];
    assign hour1              = time_q[19:16];
    assign minute10           = time_q[15:12];
    assign minute1            = time_q[11:8];
    assign second10           = time_q[7:4];
    assign second1            = time_q[3:0];
    assign state              = state_q;
    assign running            = running_q;
    assign alarm              = alarm_q;
    assign set_bus.setting_en = setting_en_q;

endmodule

// File: tb/tb_nap_timer_controller.sv
// tb/tb_nap_timer_controller.sv - directed-vector bench for nap_timer_controller

module tb_nap_timer_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       mode_key = 1'b0;
    logic       start_key = 1'b0;
    logic       cancel_key = 1'b0;
    logic [3:0] hour10, hour1, minute10, minute1, second10, second1;
    logic [2:0] state;
    logic       running, alarm;

    int vec_cnt = 0;
    int err_cnt = 0;

    nap_timer_controller_if set_if ();

    nap_timer_controller #(.ALARM_SECS(30), .SNOOZE_MIN(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .mode_key   (mode_key),
        .start_key  (start_key),
        .cancel_key (cancel_key),
        .set_bus    (set_if.master),
        .hour10     (hour10),
        .hour1      (hour1),
        .minute10   (minute10),
        .minute1    (minute1),
        .second10   (second10),
        .second1    (second1),
        .state      (state),
        .running    (running),
        .alarm      (alarm)
    );

    always #5 clock = ~clock;

    function automatic logic [23:0] cur_time();
        return {hour10, hour1, minute10, minute1, second10, second1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_mode();   mode_key = 1'b1;   step(); mode_key = 1'b0;   endtask
    task automatic pulse_start();  start_key = 1'b1;  step(); start_key = 1'b0;  endtask
    task automatic pulse_tick();   tick = 1'b1;       step(); tick = 1'b0;       endtask

    // Present digits on the setting bus; optionally assert complete in the same cycle.
    task automatic load_digits(input logic [23:0] d, input logic complete);
        set_if.set_hour10   = d[23:20];
        set_if.set_hour1    = d[19:16];
        set_if.set_minute10 = d[15:12];
        set_if.set_minute1  = d[11:8];
        set_if.set_second10 = d[7:4];
        set_if.set_second1  = d[3:0];
        set_if.set_load     = 1'b1;
        set_if.set_complete = complete;
        step();
        set_if.set_load     = 1'b0;
        set_if.set_complete = 1'b0;
    endtask

    // From IDLE/ARMED/PAUSED: set a time and start the countdown.
    task automatic run_from(input logic [23:0] d);
        pulse_mode();
        load_digits(d, 1'b1);
        pulse_start();
    endtask

    initial begin
        set_if.set_load     = 1'b0;
        set_if.set_complete = 1'b0;
        set_if.set_hour10   = 4'd0;
        set_if.set_hour1    = 4'd0;
        set_if.set_minute10 = 4'd0;
        set_if.set_minute1  = 4'd0;
        set_if.set_second10 = 4'd0;
        set_if.set_second1  = 4'd0;

        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_time", 32'(cur_time()), 32'h0);
        chk("rst_flags", {29'd0, running, alarm, set_if.setting_en}, 32'd0);
        reset = 1'b1;
        step();

        // T1: reset in the middle of a countdown
        run_from(24'h001000);
        chk("t1_running", 32'(state), 32'd3);
        pulse_tick();
        chk("t1_dec", 32'(cur_time()), 32'h000959);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        chk("t1_state", 32'(state), 32'd0);
        chk("t1_time", 32'(cur_time()), 32'h0);
        chk("t1_flags", {30'd0, running, alarm}, 32'd0);
        step();

        // Start with zero time in IDLE is ignored
        pulse_start();
        chk("idle_start0", 32'(state), 32'd0);

        // T2: set 00:01:05, arm, count to alarm
        pulse_mode();
        chk("t2_setting", 32'(state), 32'd1);
        chk("t2_set_en", 32'(set_if.setting_en), 32'd1);
        load_digits(24'h000105, 1'b0);
        chk("t2_loaded", 32'(cur_time()), 32'h000105);
        set_if.set_complete = 1'b1;
        step();
        set_if.set_complete = 1'b0;
        chk("t2_armed", 32'(state), 32'd2);
        chk("t2_set_en_off", 32'(set_if.setting_en), 32'd0);
        pulse_start();
        chk("t2_run", {29'd0, state}, 32'd3);
        chk("t2_running", 32'(running), 32'd1);
        for (int i = 0; i < 64; i++) pulse_tick();
        chk("t2_64", 32'(cur_time()), 32'h000001);
        chk("t2_64_state", 32'(state), 32'd3);
        pulse_tick();
        chk("t2_alarm_state", 32'(state), 32'd5);
        chk("t2_alarm", 32'(alarm), 32'd1);
        chk("t2_zero", 32'(cur_time()), 32'h0);

        // T6a: alarm times out after exactly 30 ticks
        for (int i = 0; i < 29; i++) pulse_tick();
        chk("t6_29", 32'(state), 32'd5);
        pulse_tick();
        chk("t6_30", 32'(state), 32'd0);
        chk("t6_alarm_off", 32'(alarm), 32'd0);

        // T6b: complete with time 0 returns to IDLE
        pulse_mode();
        set_if.set_complete = 1'b1;
        step();
        set_if.set_complete = 1'b0;
        chk("t6_zero_complete", 32'(state), 32'd0);

        // T4: per-digit clamping (minute10=7 -> 5, second1=12 -> 9)
        pulse_mode();
        load_digits(24'h00700C, 1'b0);
        chk("t4_clamp", 32'(cur_time()), 32'h005009);
        chk("t4_state", 32'(state), 32'd1);
        load_digits(24'hCDEFAB, 1'b0);
        chk("t4_clamp_all", 32'(cur_time()), 32'h995959);
        pulse_start();
        chk("t4_start_ignored", 32'(state), 32'd1);
        load_digits(24'h010000, 1'b1);
        chk("t4_armed", 32'(state), 32'd2);

        // T3: 01:00:00 -> 00:59:59, paused ticks are ignored
        pulse_start();
        pulse_tick();
        chk("t3_borrow", 32'(cur_time()), 32'h005959);
        pulse_start();
        chk("t3_paused", 32'(state), 32'd4);
        chk("t3_run_off", 32'(running), 32'd0);
        for (int i = 0; i < 3; i++) pulse_tick();
        chk("t3_frozen", 32'(cur_time()), 32'h005959);
        chk("t3_still_paused", 32'(state), 32'd4);

        // tick + start together: decrement and pause
        pulse_start();
        tick = 1'b1; start_key = 1'b1; step(); tick = 1'b0; start_key = 1'b0;
        chk("tick_start_time", 32'(cur_time()), 32'h005958);
        chk("tick_start_state", 32'(state), 32'd4);

        // Hour10 borrow: 10:00:00 -> 09:59:59
        pulse_mode();
        load_digits(24'h100000, 1'b1);
        pulse_start();
        pulse_tick();
        chk("hour_borrow", 32'(cur_time()), 32'h095959);
        cancel_key = 1'b1; step(); cancel_key = 1'b0;
        chk("cancel_run", {8'(state), cur_time()}, 32'h0);

        // Decrement to zero with start: alarm beats pause
        run_from(24'h000001);
        tick = 1'b1; start_key = 1'b1; step(); tick = 1'b0; start_key = 1'b0;
        chk("zero_start_alarm", 32'(state), 32'd5);

        // T5: snooze, then cancel+start -> IDLE
        pulse_mode();
        chk("t5_snooze_time", 32'(cur_time()), 32'h000500);
        chk("t5_snooze_state", {29'd0, state}, 32'd3);
        chk("t5_alarm_off", 32'(alarm), 32'd0);
        cancel_key = 1'b1; start_key = 1'b1; step(); cancel_key = 1'b0; start_key = 1'b0;
        chk("t5_cancel_state", 32'(state), 32'd0);
        chk("t5_cancel_time", 32'(cur_time()), 32'h0);

        // Start stops the alarm
        run_from(24'h000001);
        pulse_tick();
        chk("alarm_again", 32'(alarm), 32'd1);
        pulse_start();
        chk("alarm_stop", {8'(state), cur_time()}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
